// File: rtl/alu_pkg.sv
// Shared ALU function codes, MUL sequencer state encoding and a reference ALU evaluator.
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_XOR  = 4'b0010;
   localparam logic [3:0] ALU_XNOR = 4'b0011;
   localparam logic [3:0] ALU_ADD  = 4'b0100;
   localparam logic [3:0] ALU_SUB  = 4'b1100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ITER = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Behaviour of the shared EX-stage ALU, usable wherever a model of it is needed.
   function automatic logic [31:0] alu_eval(input logic [3:0] func,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
      logic [31:0] r;
      case (func)
         ALU_AND:  r = a & b;
         ALU_OR:   r = a | b;
         ALU_XOR:  r = a ^ b;
         ALU_XNOR: r = ~(a ^ b);
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a - b;
         ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
         default:  r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add MUL sequencer that borrows the shared EX-stage ALU for one conditional ADD
// per multiplier bit; stalls the pipeline while busy.
module alu_mul_sequencer
   import alu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic            alu_sel_o,
   output logic [XLEN-1:0] alu_in1_o,
   output logic [XLEN-1:0] alu_in2_o,
   output logic [3:0]      alu_func_o,
   input  logic [XLEN-1:0] alu_out_i
);

   localparam int CNT_W = $clog2(XLEN);

   logic [1:0]      state;
   logic [XLEN-1:0] acc, mcand, mplier, result_q;
   logic [CNT_W-1:0] cnt;

   logic [XLEN-1:0] acc_nxt, mplier_sh;
   logic            last;

   always_comb begin
      acc_nxt   = mplier[0] ? alu_out_i : acc;
      mplier_sh = mplier >> 1;
      // Early exit once no set multiplier bits remain for the following iterations.
      last      = (cnt == CNT_W'(XLEN-1)) || (EARLY_EXIT && (mplier_sh == '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
         result_q <= '0;
      end else begin
         case (state)
            ST_IDLE: if (start_i && !flush_i) begin
               state  <= ST_ITER;
               acc    <= '0;
               mcand  <= op_a_i;
               mplier <= op_b_i;
               cnt    <= '0;
            end
            ST_ITER: if (flush_i) begin
               state <= ST_IDLE;
            end else begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier_sh;
               // Hold the counter on the exit cycle so it never wraps.
               if (!last) cnt <= cnt + 1'b1;
               if (last) begin
                  state    <= ST_DONE;
                  result_q <= acc_nxt;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy_o     = (state != ST_IDLE);
      done_o     = (state == ST_DONE);
      alu_sel_o  = (state == ST_ITER);
      alu_in1_o  = alu_sel_o ? acc   : '0;
      alu_in2_o  = alu_sel_o ? mcand : '0;
      alu_func_o = ALU_ADD;
      result_o   = result_q;
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Drives one EARLY_EXIT=0 and one EARLY_EXIT=1 sequencer, each closed over its own ALU,
// and checks timing and products against an arithmetic model.
module tb_alu_mul_sequencer;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0]        start, flush, busy, done, sel;
   logic [1:0][31:0]  op_a, op_b, res, in1, in2, aout, exp_res;
   logic [1:0][3:0]   func;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   // Index 0: EARLY_EXIT=0, index 1: EARLY_EXIT=1.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      alu_mul_sequencer #(.XLEN(32), .EARLY_EXIT(g != 0)) u_dut (
         .clk(clk), .rst_n(rst_n), .start_i(start[g]), .flush_i(flush[g]),
         .op_a_i(op_a[g]), .op_b_i(op_b[g]), .busy_o(busy[g]), .done_o(done[g]),
         .result_o(res[g]), .alu_sel_o(sel[g]), .alu_in1_o(in1[g]), .alu_in2_o(in2[g]),
         .alu_func_o(func[g]), .alu_out_i(aout[g])
      );
      assign aout[g] = alu_eval(func[g], in1[g], in2[g]);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] f;
      f = 64'(a) * 64'(b);
      return f[31:0];
   endfunction

   function automatic int exp_k(input int ee, input logic [31:0] b);
      if (ee == 0) return 32;
      for (int i = 31; i >= 0; i--) if (b[i]) return i + 1;
      return 1;
   endfunction

   // Start an op on dut d in the current cycle T; sample s is cycle T+s.
   // ign_s>0: stray start at T+ign_s. flush_s>0 (<=k): flush at T+flush_s.
   task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                         input int ign_s, input int flush_s);
      int k, klim, done_s, ndone, err;
      bit fl;
      logic [31:0] exp_p;
      k     = exp_k(d, b);
      fl    = (flush_s > 0);
      klim  = fl ? ((k < flush_s) ? k : flush_s) : k;
      exp_p = fl ? exp_res[d] : prod(a, b);
      op_a[d] = a; op_b[d] = b; start[d] = 1'b1;
      tick;
      start[d] = 1'b0;
      done_s = 0; ndone = 0; err = 0;
      for (int s = 1; s <= 40; s++) begin
         if (done[d]) begin
            ndone++;
            if (done_s == 0) done_s = s;
         end
         if (sel[d] !== (s <= klim)) err++;
         if (busy[d] !== ((s <= klim) || (!fl && s == k + 1))) err++;
         if (!sel[d] && (in1[d] != 0 || in2[d] != 0)) err++;
         if (fl ? (s == flush_s + 1) : (s == k + 2)) break;
         if (s == ign_s) begin
            start[d] = 1'b1; op_a[d] = $urandom; op_b[d] = $urandom;
         end
         if (s == flush_s) flush[d] = 1'b1;
         tick;
         start[d] = 1'b0;
         flush[d] = 1'b0;
      end
      chk($sformatf("d%0d done_cycle a=%h b=%h", d, a, b), done_s, fl ? 0 : k + 1);
      chk($sformatf("d%0d done_count", d), ndone, fl ? 0 : 1);
      chk($sformatf("d%0d seq_errs", d), err, 0);
      chk($sformatf("d%0d result a=%h b=%h", d, a, b), res[d], exp_p);
      exp_res[d] = exp_p;
   endtask

   initial begin
      start = '0; flush = '0; op_a = '0; op_b = '0; exp_res = '0;
      #12;
      chk("rst_ctl", {26'b0, busy, done, sel}, 32'h0);
      chk("rst_res0", res[0], 32'h0);
      chk("rst_res1", res[1], 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick;

      for (int d = 1; d >= 0; d--) begin
         run_op(d, 32'd3, 32'd5, 0, 0);
         run_op(d, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
         run_op(d, 32'h1234_5678, 32'h0, 0, 0);
         run_op(d, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0);
         run_op(d, 32'd3, 32'd5, 0, 2);
         run_op(d, 32'd7, 32'd9, 0, 0);
      end

      // Async reset in the middle of an iteration.
      op_a[1] = 32'd3; op_b[1] = 32'hF000_0000; start[1] = 1'b1;
      tick;
      start[1] = 1'b0;
      tick;
      tick;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ctl", {26'b0, busy, done, sel}, 32'h0);
      chk("arst_res", res[1], 32'h0);
      chk("arst_in", in1[1] | in2[1], 32'h0);
      exp_res = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick;
      run_op(1, 32'd3, 32'd5, 0, 0);

      for (int d = 0; d < 2; d++) begin
         repeat (20) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 32);
            run_op(d, ra, rb, $urandom_range(0, 6), 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
